// File: rtl/mac_pkg.sv
// mac_pkg: shared types and constants for the signed MAC accumulator family.
//   state_e     - two-state frame FSM encoding (ACCUM, DONE)
//   PROD_W      - width of the signed product from the 4x4 multiplier
//   ACC_W_DEF   - default accumulator / result width
//   MAX_LEN_DEF - default maximum number of beats per frame
package mac_pkg;

    localparam int PROD_W      = 8;
    localparam int ACC_W_DEF   = 16;
    localparam int MAX_LEN_DEF = 16;

    typedef enum logic [0:0] {
        ST_ACCUM = 1'b0,
        ST_DONE  = 1'b1
    } state_e;

endpackage

// File: rtl/signed_mac_accumulator_if.sv
// signed_mac_accumulator_if: product input stream plus frame result stream.
//   in_valid/in_ready/in_prod/in_last         - product beat channel
//   out_valid/out_ready/out_acc/out_sat/out_count - frame result channel
// Handshake rule for both channels: a transfer happens on a rising clock edge
// where valid and ready are both high. A source holding valid keeps its
// payload stable until the transfer; ready never depends on valid.
interface signed_mac_accumulator_if
    import mac_pkg::*;
#(
    parameter int ACC_W = ACC_W_DEF,
    parameter int CNT_W = 5
);
    logic              in_valid;
    logic              in_ready;
    logic [PROD_W-1:0] in_prod;
    logic              in_last;
    logic              out_valid;
    logic              out_ready;
    logic [ACC_W-1:0]  out_acc;
    logic              out_sat;
    logic [CNT_W-1:0]  out_count;

    // Producer of beats / consumer of results.
    modport master (
        output in_valid, in_prod, in_last, out_ready,
        input  in_ready, out_valid, out_acc, out_sat, out_count
    );

    // The accumulator itself.
    modport slave (
        input  in_valid, in_prod, in_last, out_ready,
        output in_ready, out_valid, out_acc, out_sat, out_count
    );
endinterface

// File: rtl/sat_add.sv
// sat_add: combinational saturating signed add.
//   acc_i  - ACC_W-bit signed running value
//   prod_i - PROD_W-bit signed addend
//   sum_o  - acc_i + prod_i clamped to the ACC_W signed range
//   clip_o - high when the clamp was applied
module sat_add #(
    parameter int ACC_W  = 16,
    parameter int PROD_W = 8
) (
    input  logic signed [ACC_W-1:0]  acc_i,
    input  logic signed [PROD_W-1:0] prod_i,
    output logic signed [ACC_W-1:0]  sum_o,
    output logic                     clip_o
);
    localparam logic signed [ACC_W-1:0] POS_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] NEG_MIN = {1'b1, {(ACC_W-1){1'b0}}};

    // One guard bit is enough: |prod| is far smaller than the ACC_W range.
    logic [ACC_W:0] wide;

    assign wide = {acc_i[ACC_W-1], acc_i}
                + {{(ACC_W+1-PROD_W){prod_i[PROD_W-1]}}, prod_i};

    always_comb begin
        sum_o  = wide[ACC_W-1:0];
        clip_o = 1'b0;
        // Guard bit disagreeing with the sign bit means the true sum left range.
        if (wide[ACC_W] != wide[ACC_W-1]) begin
            clip_o = 1'b1;
            sum_o  = wide[ACC_W] ? NEG_MIN : POS_MAX;
        end
    end
endmodule

// File: rtl/signed_mac_accumulator.sv
// signed_mac_accumulator: sums a frame of signed 8-bit products into a
// saturating ACC_W-bit accumulator and presents the frame result.
//   clk         - rising-edge clock
//   rst_n       - synchronous active-low reset
//   flush       - synchronous frame abort (drops any pending result)
//   bus         - slave side of the beat / result streams
//   dbg_state_o - current FSM state (0 = ACCUM, 1 = DONE)
module signed_mac_accumulator
    import mac_pkg::*;
#(
    parameter int ACC_W   = ACC_W_DEF,
    parameter int MAX_LEN = MAX_LEN_DEF,
    parameter int CNT_W   = $clog2(MAX_LEN + 1)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush,
    signed_mac_accumulator_if.slave  bus,
    output logic [0:0]               dbg_state_o
);
    localparam logic [0:0]       S_ACCUM = ST_ACCUM;
    localparam logic [0:0]       S_DONE  = ST_DONE;
    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_LEN);

    logic [0:0]              state_q, state_d;
    logic signed [ACC_W-1:0] acc_q, acc_d;
    logic [CNT_W-1:0]        count_q, count_d;
    logic                    sat_q, sat_d;
    logic [ACC_W-1:0]        out_acc_q, out_acc_d;
    logic                    out_sat_q, out_sat_d;
    logic [CNT_W-1:0]        out_count_q, out_count_d;

    logic signed [ACC_W-1:0] sum;
    logic                    clip;
    logic                    in_ready_w;
    logic                    accept;
    logic                    close;
    logic                    out_hs;
    logic [CNT_W-1:0]        count_inc;

    sat_add #(
        .ACC_W  (ACC_W),
        .PROD_W (PROD_W)
    ) u_sat_add (
        .acc_i  (acc_q),
        .prod_i (bus.in_prod),
        .sum_o  (sum),
        .clip_o (clip)
    );

    // flush is the only input allowed to reach in_ready combinationally.
    assign in_ready_w = (state_q == S_ACCUM) && !flush;
    assign accept     = bus.in_valid && in_ready_w;
    assign count_inc  = count_q + CNT_W'(1);
    assign close      = accept && (bus.in_last || (count_inc == MAX_CNT));
    assign out_hs     = (state_q == S_DONE) && bus.out_ready;

    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        count_d     = count_q;
        sat_d       = sat_q;
        out_acc_d   = out_acc_q;
        out_sat_d   = out_sat_q;
        out_count_d = out_count_q;
        if (flush) begin
            // Result latches are left alone; dropping out_valid hides them.
            state_d = S_ACCUM;
            acc_d   = '0;
            count_d = '0;
            sat_d   = 1'b0;
        end else if (state_q == S_ACCUM) begin
            if (accept) begin
                acc_d   = sum;
                count_d = count_inc;
                sat_d   = sat_q | clip;
                if (close) begin
                    state_d     = S_DONE;
                    out_acc_d   = sum;
                    out_sat_d   = sat_q | clip;
                    out_count_d = count_inc;
                end
            end
        end else if (out_hs) begin
            state_d = S_ACCUM;
            acc_d   = '0;
            count_d = '0;
            sat_d   = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= S_ACCUM;
            acc_q       <= '0;
            count_q     <= '0;
            sat_q       <= 1'b0;
            out_acc_q   <= '0;
            out_sat_q   <= 1'b0;
            out_count_q <= '0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            count_q     <= count_d;
            sat_q       <= sat_d;
            out_acc_q   <= out_acc_d;
            out_sat_q   <= out_sat_d;
            out_count_q <= out_count_d;
        end
    end

    assign bus.in_ready  = in_ready_w;
    assign bus.out_valid = (state_q == S_DONE);
    assign bus.out_acc   = out_acc_q;
    assign bus.out_sat   = out_sat_q;
    assign bus.out_count = out_count_q;
    assign dbg_state_o   = state_q;
endmodule
